cpu_run_controller: RTL and testbench

Synthesizable run controller for the pipelined RISC-V core. It sequences core reset and counts cycles and retired instructions. It detects program end through a halt-loop instruction, an optional tohost write, or a cycle timeout, then freezes the core and reports pass/fail. It sits between the bench's clock/reset sources and the core top, which lets the bench sequence runs of many programs without hand-timed delays.

---
 rtl/cpu_run_ctrl_pkg.sv | 13 +
 rtl/cpu_run_controller_sat_counter.sv | 31 +++
 rtl/cpu_run_controller.sv | 142 ++++++++++++++
 tb/tb_cpu_run_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  // jal x0,0 -- the self-loop programs use to signal completion
  localparam logic [31:0] HALT_INSTR = 32'h0000_006F;

endpackage

// File: rtl/cpu_run_controller_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Sequences core reset, counts RUN cycles/retirements and detects program end.
// Optional tohost store detection is enabled by defining RUN_CTRL_TOHOST_EN.
module cpu_run_controller
  import cpu_run_ctrl_pkg::*;
#(
  parameter int              RESET_CYCLES   = 4,
  parameter int              TIMEOUT_CYCLES = 100000,
  parameter int              CNT_W          = 32,
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid,
  input  logic [31:0]      retire_instr,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             cpu_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int                HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic              TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   exit_code_q, exit_code_d;

  logic            halt_ev, timeout_ev, tohost_ev, tohost_pass;
  logic [XLEN-1:0] tohost_code;

  assign halt_ev    = retire_valid && (retire_instr == HALT_INSTR);
  assign timeout_ev = TO_EN && (cycle_cnt == TO_LAST);

`ifdef RUN_CTRL_TOHOST_EN
  assign tohost_ev   = mem_we && (mem_addr == TOHOST_ADDR);
  assign tohost_pass = (mem_wdata == XLEN'(1));
  assign tohost_code = mem_wdata >> 1;
`else
  logic unused_mem;
  assign unused_mem  = ^{mem_we, mem_addr, mem_wdata, TOHOST_ADDR};
  assign tohost_ev   = 1'b0;
  assign tohost_pass = 1'b0;
  assign tohost_code = '0;
`endif

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (state_q == RUN),
    .cnt_o (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  ((state_q == RUN) && retire_valid),
    .cnt_o (instret_cnt)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;
    case (state_q)
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        // Event priority: tohost, then halt, then timeout
        if (tohost_ev) begin
          state_d     = DONE;
          done_d      = 1'b1;
          pass_d      = tohost_pass;
          exit_code_d = tohost_code;
        end else if (halt_ev) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (timeout_ev) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
    cpu_rst_d = (state_d != RUN);
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_q      <= '0;
      cpu_rst_q   <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cpu_rst_q   <= cpu_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      exit_code_q <= exit_code_d;
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign running   = running_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign exit_code = exit_code_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed self-checking bench for cpu_run_controller (RESET_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_cpu_run_controller;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] JAL0 = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_instr = 32'h0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        cpu_rst, running, done, pass, timeout;
  logic [31:0] exit_code, cycle_cnt, instret_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_controller #(
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(50),
    .CNT_W         (32),
    .XLEN          (32),
    .TOHOST_ADDR   (32'h0000_1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .retire_valid(retire_valid),
    .retire_instr(retire_instr),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_rst     (cpu_rst),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .exit_code   (exit_code),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    retire_valid = 1'b0;
    retire_instr = 32'h0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cpu_rst, running, done, pass, timeout} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=10000", {cpu_rst, running, done, pass, timeout});
    end
    n_checks++;
    if ({exit_code, cycle_cnt, instret_cnt} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_values exit=%0d cyc=%0d ins=%0d want all 0", exit_code, cycle_cnt, instret_cnt);
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if ({cpu_rst, running} !== 2'b10) begin
        n_fail++;
        $display("FAIL hold_edge%0d cpu_rst/running got=%b want=10", i, {cpu_rst, running});
      end
    end
    tick();
    n_checks++;
    if ({cpu_rst, running, cycle_cnt} !== {2'b01, 32'd0}) begin
      n_fail++;
      $display("FAIL release_edge4 cpu_rst=%b running=%b cyc=%0d want 0 1 0", cpu_rst, running, cycle_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      retire_valid = (c <= 10) || (c == 20);
      retire_instr = (c == 20) ? JAL0 : ADDI;
      if (c == 20) begin
        n_checks++;
        if (done !== 1'b0 || cycle_cnt !== 32'd19) begin
          n_fail++;
          $display("FAIL halt_pre done=%b cyc=%0d want 0 19", done, cycle_cnt);
        end
      end
      tick();
    end
    idle_inputs();
    n_checks++;
    if ({done, pass, timeout, cpu_rst, running} !== 5'b11010) begin
      n_fail++;
      $display("FAIL halt_flags got=%b want=11010", {done, pass, timeout, cpu_rst, running});
    end
    n_checks++;
    if (instret_cnt !== 32'd11 || cycle_cnt !== 32'd20 || exit_code !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_counts ins=%0d cyc=%0d exit=%0d want 11 20 0", instret_cnt, cycle_cnt, exit_code);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_from_done done=%b want=0", done);
    end
    repeat (49) tick();
    n_checks++;
    if (done !== 1'b0 || cycle_cnt !== 32'd49) begin
      n_fail++;
      $display("FAIL timeout_pre done=%b cyc=%0d want 0 49", done, cycle_cnt);
    end
    tick();
    n_checks++;
    if ({done, timeout, pass, cpu_rst} !== 4'b1101 || cycle_cnt !== 32'd50 || instret_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_done flags=%b cyc=%0d ins=%0d want 1101 50 0",
               {done, timeout, pass, cpu_rst}, cycle_cnt, instret_cnt);
    end
    retire_valid = 1'b1;
    retire_instr = JAL0;
    repeat (10) tick();
    idle_inputs();
    n_checks++;
    if ({done, timeout, pass, running} !== 4'b1100 || cycle_cnt !== 32'd50 || instret_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_frozen flags=%b cyc=%0d ins=%0d want 1100 50 0",
               {done, timeout, pass, running}, cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_tohost();
    do_reset();
    repeat (3) tick();
`ifndef RUN_CTRL_TOHOST_EN
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_1000;
    mem_wdata = 32'h1;
    tick();
    n_checks++;
    if (done !== 1'b0 || exit_code !== 32'd0) begin
      n_fail++;
      $display("FAIL store_ignored done=%b exit=%0d want 0 0", done, exit_code);
    end
`endif
    retire_valid = 1'b1;
    retire_instr = JAL0;
    mem_we       = 1'b1;
    mem_addr     = 32'h0000_1000;
    mem_wdata    = 32'h7;
    tick();
    idle_inputs();
`ifdef RUN_CTRL_TOHOST_EN
    n_checks++;
    if ({done, pass, timeout} !== 3'b100 || exit_code !== 32'd3) begin
      n_fail++;
      $display("FAIL tohost_prio flags=%b exit=%0d want 100 3", {done, pass, timeout}, exit_code);
    end
    n_checks++;
    if (instret_cnt !== 32'd1 || cycle_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL tohost_counts ins=%0d cyc=%0d want 1 4", instret_cnt, cycle_cnt);
    end
`else
    n_checks++;
    if ({done, pass, timeout} !== 3'b110 || exit_code !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_no_tohost flags=%b exit=%0d want 110 0", {done, pass, timeout}, exit_code);
    end
    n_checks++;
    if (instret_cnt !== 32'd1 || cycle_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL halt_no_tohost_counts ins=%0d cyc=%0d want 1 5", instret_cnt, cycle_cnt);
    end
`endif
  endtask

  task automatic test_mid_run_reset();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      retire_valid = c[0];
      retire_instr = ADDI;
      tick();
    end
    idle_inputs();
    n_checks++;
    if (cycle_cnt !== 32'd30 || instret_cnt !== 32'd15 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre cyc=%0d ins=%0d run=%b want 30 15 1", cycle_cnt, instret_cnt, running);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0 || {cpu_rst, running, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL midrun_reset cyc=%0d ins=%0d flags=%b want 0 0 100",
               cycle_cnt, instret_cnt, {cpu_rst, running, done});
    end
    repeat (3) tick();
    n_checks++;
    if ({cpu_rst, running} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrun_hold got=%b want=10", {cpu_rst, running});
    end
    tick();
    n_checks++;
    if ({cpu_rst, running} !== 2'b01) begin
      n_fail++;
      $display("FAIL midrun_rerun got=%b want=01", {cpu_rst, running});
    end
  endtask

  task automatic test_hold_ignore();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    retire_valid = 1'b1;
    retire_instr = JAL0;
    repeat (4) tick();
    idle_inputs();
    n_checks++;
    if ({running, done, pass} !== 3'b100 || instret_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL hold_ignore flags=%b ins=%0d cyc=%0d want 100 0 0",
               {running, done, pass}, instret_cnt, cycle_cnt);
    end
    tick();
    n_checks++;
    if (cycle_cnt !== 32'd1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_then_run cyc=%0d done=%b want 1 0", cycle_cnt, done);
    end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_timeout();
    test_tohost();
    test_mid_run_reset();
    test_hold_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
